// File: rtl/dither_gen_v3_pkg.sv
// Shared types and helpers for the dither generator / synchronous demodulator.
package dither_gen_v3_pkg;

  // FSM states; encodings are visible on the o_cstate debug port.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DITHER_H = 4'd1,
    ST_WAIT_H   = 4'd2,
    ST_ACQ_H    = 4'd3,
    ST_DITHER_L = 4'd4,
    ST_WAIT_L   = 4'd5,
    ST_ACQ_L    = 4'd6,
    ST_OUT_GEN  = 4'd7
  } state_e;

  // Width of the averaging select field.
  localparam int AVG_W = 4;

  // Accumulator width: one sample width, plus log2 of the largest sample
  // count, plus one bit so that the H-L difference cannot overflow.
  function automatic int acc_w(input int dw, input int max_avg);
    return dw + max_avg + 1;
  endfunction

endpackage

// File: rtl/dither_gen_v3_if.sv
// Configuration, sample and result signals of the dither generator.
interface dither_gen_v3_if
  import dither_gen_v3_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 32
);
  logic                 i_en;
  logic signed [DW-1:0] i_dither_high;
  logic signed [DW-1:0] i_dither_low;
  logic [CW-1:0]        i_half_period;
  logic [CW-1:0]        i_wait_cnt;
  logic [AVG_W-1:0]     i_avg_sel;
  logic signed [DW-1:0] i_data;
  logic                 i_data_vld;
  logic signed [DW-1:0] o_dither_out;
  logic signed [DW-1:0] o_data;
  logic                 o_data_vld;
  logic                 o_sat;
  logic                 o_miss;
  logic [3:0]           o_cstate;

  // Loop controller side: drives config and samples, reads results.
  modport master (
    output i_en, i_dither_high, i_dither_low, i_half_period, i_wait_cnt,
           i_avg_sel, i_data, i_data_vld,
    input  o_dither_out, o_data, o_data_vld, o_sat, o_miss, o_cstate
  );

  // Generator side.
  modport slave (
    input  i_en, i_dither_high, i_dither_low, i_half_period, i_wait_cnt,
           i_avg_sel, i_data, i_data_vld,
    output o_dither_out, o_data, o_data_vld, o_sat, o_miss, o_cstate
  );
endinterface

// File: rtl/dither_gen_v3_accum.sv
// Per-half sample accumulator: clears, adds valid samples until 2^avg_sel
// have been taken, and flags completion.
module dither_gen_v3_accum
  import dither_gen_v3_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MAX_AVG = 6
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  clr_i,
  input  logic                                  add_i,
  input  logic signed [DW-1:0]                  data_i,
  input  logic [AVG_W-1:0]                      avg_sel_i,
  output logic signed [acc_w(DW, MAX_AVG)-1:0]  acc_o,
  output logic                                  done_o
);
  localparam int ACC_W = acc_w(DW, MAX_AVG);
  localparam int CNT_W = MAX_AVG + 1;

  logic signed [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        target;

  // Sample target N = 2^avg_sel; avg_sel is already clamped to MAX_AVG.
  assign target = {{(CNT_W-1){1'b0}}, 1'b1} << avg_sel_i;
  assign done_o = (cnt_q == target);
  assign acc_o  = acc_q;

  // Accumulate sign-extended samples; samples beyond N are ignored.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (add_i && !done_o) begin
      acc_q <= acc_q + {{(ACC_W-DW){data_i[DW-1]}}, data_i};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dither_gen_v3.sv
// Square-wave dither generator with synchronous demodulation: drives the
// high/low level, averages each half, emits saturated (avg_H - avg_L) once
// per period.
module dither_gen_v3
  import dither_gen_v3_pkg::*;
#(
  parameter int DW      = 32,
  parameter int CW      = 32,
  parameter int MAX_AVG = 6
) (
  input logic             i_clk,
  input logic             i_rst_n,
  dither_gen_v3_if.slave  bus
);
  localparam int ACC_W = acc_w(DW, MAX_AVG);
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [CW-1:0]           half_cnt_q, half_cnt_d;
  logic signed [DW-1:0]    high_q, low_q;
  logic [CW-1:0]           hp_q, wait_q;
  logic [AVG_W-1:0]        avg_q;
  logic signed [DW-1:0]    dither_q, data_q;
  logic                    vld_q, sat_q, miss_q;

  logic                    h_end, l_end, wait_done;
  logic                    load_cfg, enter_l, go_idle;
  logic                    clr_h, clr_l, add_h, add_l, out_gen;
  logic [CW-1:0]           hp_in;
  logic [AVG_W-1:0]        avg_in;
  logic signed [ACC_W-1:0] acc_h, acc_l, diff, shifted;
  logic                    done_h, done_l;
  logic signed [DW-1:0]    res;
  logic                    res_sat;

  // The H half ends on its last count; the L half hands its last clock to OUT_GEN.
  assign h_end     = (half_cnt_q == hp_q - CW'(1));
  assign l_end     = (half_cnt_q == hp_q - CW'(2));
  assign wait_done = (half_cnt_q >= wait_q);
  assign hp_in     = (bus.i_half_period < CW'(4)) ? CW'(4) : bus.i_half_period;
  assign avg_in    = (bus.i_avg_sel > AVG_W'(MAX_AVG)) ? AVG_W'(MAX_AVG) : bus.i_avg_sel;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; half-boundary exits take priority over the settle wait.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (bus.i_en) state_d = ST_DITHER_H;
      ST_DITHER_H: state_d = (wait_q == '0) ? ST_ACQ_H : ST_WAIT_H;
      ST_WAIT_H:   if (h_end) state_d = ST_DITHER_L;
                   else if (wait_done) state_d = ST_ACQ_H;
      ST_ACQ_H:    if (h_end) state_d = ST_DITHER_L;
      ST_DITHER_L: state_d = (wait_q == '0) ? ST_ACQ_L : ST_WAIT_L;
      ST_WAIT_L:   if (l_end) state_d = ST_OUT_GEN;
                   else if (wait_done) state_d = ST_ACQ_L;
      ST_ACQ_L:    if (l_end) state_d = ST_OUT_GEN;
      ST_OUT_GEN:  state_d = bus.i_en ? ST_DITHER_H : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: entry strobes, accumulator control, result capture.
  always_comb begin
    load_cfg = (state_d == ST_DITHER_H);
    enter_l  = (state_d == ST_DITHER_L);
    go_idle  = (state_d == ST_IDLE);
    clr_h    = (state_q == ST_DITHER_H);
    clr_l    = (state_q == ST_DITHER_L);
    add_h    = (state_q == ST_ACQ_H) && bus.i_data_vld;
    add_l    = (state_q == ST_ACQ_L) && bus.i_data_vld;
    out_gen  = (state_q == ST_OUT_GEN);
  end

  // Half counter restarts at each dither step; shadow config loads only at DITHER_H.
  assign half_cnt_d = (load_cfg || enter_l || go_idle) ? '0 : half_cnt_q + CW'(1);

  // Half counter, shadowed configuration and the dither level register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      half_cnt_q <= '0;
      high_q     <= '0;
      low_q      <= '0;
      hp_q       <= '0;
      wait_q     <= '0;
      avg_q      <= '0;
      dither_q   <= '0;
    end else begin
      half_cnt_q <= half_cnt_d;
      if (load_cfg) begin
        high_q   <= bus.i_dither_high;
        low_q    <= bus.i_dither_low;
        hp_q     <= hp_in;
        wait_q   <= bus.i_wait_cnt;
        avg_q    <= avg_in;
        dither_q <= bus.i_dither_high;
      end else if (enter_l) begin
        dither_q <= low_q;
      end else if (go_idle) begin
        dither_q <= '0;
      end
    end
  end

  dither_gen_v3_accum #(.DW(DW), .MAX_AVG(MAX_AVG)) u_acc_h (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clr_i(clr_h), .add_i(add_h),
    .data_i(bus.i_data), .avg_sel_i(avg_q), .acc_o(acc_h), .done_o(done_h)
  );

  dither_gen_v3_accum #(.DW(DW), .MAX_AVG(MAX_AVG)) u_acc_l (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .clr_i(clr_l), .add_i(add_l),
    .data_i(bus.i_data), .avg_sel_i(avg_q), .acc_o(acc_l), .done_o(done_l)
  );

  // Difference of sums scaled back to a mean, then clamped to the output range.
  always_comb begin
    diff    = acc_h - acc_l;
    shifted = diff >>> avg_q;
    res     = shifted[DW-1:0];
    res_sat = 1'b0;
    if (shifted > MAX_V) begin
      res     = MAX_V[DW-1:0];
      res_sat = 1'b1;
    end else if (shifted < MIN_V) begin
      res     = MIN_V[DW-1:0];
      res_sat = 1'b1;
    end
  end

  // Result registers update on the edge leaving OUT_GEN; short periods only pulse o_miss.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      sat_q  <= 1'b0;
      vld_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      vld_q  <= out_gen && done_h && done_l;
      miss_q <= out_gen && !(done_h && done_l);
      if (out_gen && done_h && done_l) begin
        data_q <= res;
        sat_q  <= res_sat;
      end
    end
  end

  assign bus.o_dither_out = dither_q;
  assign bus.o_data       = data_q;
  assign bus.o_data_vld   = vld_q;
  assign bus.o_sat        = sat_q;
  assign bus.o_miss       = miss_q;
  assign bus.o_cstate     = state_q;

endmodule

// File: tb/tb_dither_gen_v3.sv
// Directed bench for dither_gen_v3: a 32-bit instance for timing, gating,
// shadowing and reset, and a 16-bit instance for saturation and clamping.
module tb_dither_gen_v3;
  import dither_gen_v3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dither_gen_v3_if #(.DW(32), .CW(32)) bus32 ();
  dither_gen_v3_if #(.DW(16), .CW(32)) bus16 ();

  dither_gen_v3 #(.DW(32), .CW(32), .MAX_AVG(6)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus32)
  );
  dither_gen_v3 #(.DW(16), .CW(32), .MAX_AVG(6)) u_dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus16)
  );

  int checks = 0;
  int failures = 0;
  int vld32_n = 0, miss32_n = 0, vld16_n = 0, miss16_n = 0;

  // Detector model: the sample follows the sign of the applied dither level.
  logic signed [31:0] pos32 = 32'sd1000, neg32 = -32'sd2100;
  logic signed [15:0] pos16 = 16'sd30000, neg16 = -16'sd30000;
  logic half_rate32 = 1'b0;
  logic tog = 1'b0;

  always @(negedge clk) begin
    bus32.i_data     = (bus32.o_dither_out > 0) ? pos32 : neg32;
    bus32.i_data_vld = half_rate32 ? tog : 1'b1;
    bus16.i_data     = (bus16.o_dither_out > 0) ? pos16 : neg16;
    bus16.i_data_vld = 1'b1;
    tog = ~tog;
    if (bus32.o_data_vld === 1'b1) vld32_n++;
    if (bus32.o_miss === 1'b1)     miss32_n++;
    if (bus16.o_data_vld === 1'b1) vld16_n++;
    if (bus16.o_miss === 1'b1)     miss16_n++;
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return bus32.o_data_vld;
      1:       return bus32.o_miss;
      2:       return bus16.o_data_vld;
      default: return bus16.o_miss;
    endcase
  endfunction

  // Step until the selected strobe is seen (or budget runs out); clks = steps taken.
  task automatic wait_pulse(input int sel, input int budget, input string tag,
                            output int clks);
    int k = 0;
    do begin
      step(1);
      k++;
    end while (sig_sel(sel) !== 1'b1 && k < budget);
    check(tag, sig_sel(sel), 1'b1);
    clks = k;
  endtask

  task automatic wait_state32(input state_e st, input int budget, input string tag,
                              output int clks);
    int k = 0;
    while (bus32.o_cstate !== st && k < budget) begin
      step(1);
      k++;
    end
    check(tag, bus32.o_cstate, st);
    clks = k;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, v0, m0;
    bus32.i_en = 1'b0;           bus16.i_en = 1'b0;
    bus32.i_dither_high = 4096;  bus16.i_dither_high = 1000;
    bus32.i_dither_low  = -4200; bus16.i_dither_low  = -1000;
    bus32.i_half_period = 100;   bus16.i_half_period = 100;
    bus32.i_wait_cnt    = 9;     bus16.i_wait_cnt    = 9;
    bus32.i_avg_sel     = 4;     bus16.i_avg_sel     = 4;

    // Reset state.
    step(2);
    check("rst_cstate", bus32.o_cstate, ST_IDLE);
    check("rst_dither", bus32.o_dither_out, 0);
    check("rst_data",   bus32.o_data, 0);
    check("rst_vld",    bus32.o_data_vld, 0);
    check("rst_sat",    bus32.o_sat, 0);
    check("rst_miss",   bus32.o_miss, 0);
    rst_n = 1'b1;
    step(2);
    check("idle_no_en", bus32.o_cstate, ST_IDLE);

    // 1: nominal demodulation and period.
    bus32.i_en = 1'b1;
    wait_pulse(0, 600, "t1_vld1", n);
    check("t1_data", bus32.o_data, 3100);
    check("t1_sat",  bus32.o_sat, 0);
    wait_pulse(0, 300, "t1_vld2", n);
    check("t1_period", n, 200);
    check("t1_data2",  bus32.o_data, 3100);
    wait_state32(ST_ACQ_H, 50, "t1_acq_h", n);
    check("t1_lvl_h", bus32.o_dither_out, 4096);
    wait_state32(ST_ACQ_L, 200, "t1_acq_l", n);
    check("t1_lvl_l", bus32.o_dither_out, -4200);

    // 2: samples valid every second clock still fill both halves.
    half_rate32 = 1'b1;
    m0 = miss32_n;
    wait_pulse(0, 450, "t2_vld1", n);
    wait_pulse(0, 300, "t2_vld2", n);
    check("t2_data",    bus32.o_data, 3100);
    check("t2_no_miss", miss32_n, m0);

    // 3: acquisition window too short -> o_miss each period, result held.
    half_rate32 = 1'b0;
    bus32.i_half_period = 20;
    wait_pulse(1, 450, "t3_miss1", n);
    v0 = vld32_n;
    wait_pulse(1, 100, "t3_miss2", n);
    check("t3_period", n, 40);
    check("t3_data",   bus32.o_data, 3100);
    check("t3_sat",    bus32.o_sat, 0);
    check("t3_no_vld", vld32_n, v0);

    // 5: config changes mid-period wait for the next DITHER_H.
    bus32.i_half_period = 100;
    step(1);
    wait_state32(ST_DITHER_H, 60, "t5_dh0", n);
    wait_state32(ST_ACQ_H, 50, "t5_acq_h", n);
    bus32.i_dither_high = 8000;
    bus32.i_half_period = 50;
    step(5);
    check("t5_lvl_h_old", bus32.o_dither_out, 4096);
    wait_state32(ST_ACQ_L, 200, "t5_acq_l", n);
    check("t5_lvl_l", bus32.o_dither_out, -4200);
    wait_state32(ST_DITHER_H, 200, "t5_dh1", n);
    check("t5_lvl_h_new", bus32.o_dither_out, 8000);
    step(1);
    wait_state32(ST_DITHER_H, 150, "t5_dh2", n);
    check("t5_period", n + 1, 100);
    bus32.i_dither_high = 4096;
    bus32.i_half_period = 100;

    // 6: drop enable mid-period -> period completes, then IDLE.
    wait_state32(ST_WAIT_H, 50, "t6_wait_h", n);
    bus32.i_en = 1'b0;
    v0 = vld32_n;
    wait_pulse(0, 200, "t6_vld", n);
    check("t6_data",   bus32.o_data, 3100);
    check("t6_idle",   bus32.o_cstate, ST_IDLE);
    check("t6_dither", bus32.o_dither_out, 0);
    step(50);
    check("t6_one_vld",   vld32_n, v0 + 1);
    check("t6_stay_idle", bus32.o_cstate, ST_IDLE);

    // Reset mid-ACQ_H clears everything immediately.
    bus32.i_en = 1'b1;
    wait_state32(ST_ACQ_H, 50, "t6_acq_h", n);
    rst_n = 1'b0;
    #1;
    check("arst_cstate", bus32.o_cstate, ST_IDLE);
    check("arst_dither", bus32.o_dither_out, 0);
    check("arst_data",   bus32.o_data, 0);
    check("arst_vld",    bus32.o_data_vld, 0);
    check("arst_miss",   bus32.o_miss, 0);
    step(2);
    rst_n = 1'b1;
    bus32.i_en = 1'b0;
    step(3);
    check("arst_after_idle", bus32.o_cstate, ST_IDLE);
    check("arst_after_data", bus32.o_data, 0);

    // 4: saturation on the 16-bit instance, both signs, then recovery.
    bus16.i_en = 1'b1;
    wait_pulse(2, 600, "t4_vld1", n);
    check("t4_pos_sat_data", bus16.o_data, 32767);
    check("t4_pos_sat_flag", bus16.o_sat, 1);
    pos16 = -16'sd30000;
    neg16 = 16'sd30000;
    wait_pulse(2, 300, "t4_vld2", n);
    check("t4_neg_sat_data", bus16.o_data, -32768);
    check("t4_neg_sat_flag", bus16.o_sat, 1);
    pos16 = 16'sd100;
    neg16 = -16'sd100;
    step(50);
    check("t4_sat_held", bus16.o_sat, 1);
    wait_pulse(2, 300, "t4_vld3", n);
    check("t4_data", bus16.o_data, 200);
    check("t4_sat",  bus16.o_sat, 0);

    // avg_sel above MAX_AVG is clamped: 64 samples still fit the windows.
    bus16.i_avg_sel = 15;
    m0 = miss16_n;
    wait_pulse(2, 300, "avg_clamp_vld1", n);
    wait_pulse(2, 300, "avg_clamp_vld2", n);
    check("avg_clamp_data",    bus16.o_data, 200);
    check("avg_clamp_no_miss", miss16_n, m0);

    // half_period below 4 runs as 4: 8-clock period, one sample per half.
    bus16.i_half_period = 1;
    bus16.i_wait_cnt    = 0;
    bus16.i_avg_sel     = 0;
    wait_pulse(2, 300, "hp_min_vld1", n);
    wait_pulse(2, 40,  "hp_min_vld2", n);
    check("hp_min_period", n, 8);
    check("hp_min_data",   bus16.o_data, 200);

    // Wait longer than the half: straight to the next half, no samples.
    bus16.i_wait_cnt = 5;
    wait_pulse(3, 40, "wait_overrun_miss1", n);
    wait_pulse(3, 40, "wait_overrun_miss2", n);
    check("wait_overrun_period", n, 8);
    check("wait_overrun_data",   bus16.o_data, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
